// File: rtl/instr_serial_encoder.sv
// Packs a decoded instruction field bundle into 16-bit instruction words and shifts them out bit-serially.
// Define INSTR_ENC_PARITY_EN to append an even-parity bit after each word.
module instr_serial_encoder #(
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  opcode,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [2:0]  rd,
  input  logic [3:0]  alu_op,
  input  logic [3:0]  mem_op,
  input  logic [2:0]  b_type,
  input  logic [3:0]  offset,
  input  logic [8:0]  addr_offset,
  input  logic        jump_type,
  input  logic [15:0] imm,
  output logic        ser_data,
  output logic        ser_valid,
  output logic        ser_first,
  input  logic        ser_ready,
  output logic        busy,
  output logic        err
);

`ifdef INSTR_ENC_PARITY_EN
  localparam int CW       = 5;
  localparam int LAST_BIT = 16;
`else
  localparam int CW       = 4;
  localparam int LAST_BIT = 15;
`endif
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] OP_R   = 3'd0;
  localparam logic [2:0] OP_I   = 3'd1;
  localparam logic [2:0] OP_B   = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_M   = 3'd4;
  localparam logic [2:0] OP_SYS = 3'd5;

  typedef enum logic [1:0] {IDLE, SEND_W0, SEND_W1, GAP} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [15:0]     r_word0;
  logic [15:0]     r_word1;
  logic            r_double;
  logic [CW-1:0]   r_bitCnt;
  logic [GW-1:0]   r_gapCnt;
  logic            r_err;

  logic [15:0]     w_word0;
  logic            w_double;
  logic            w_reject;
  logic            w_accept;
  logic            w_sending;
  logic            w_bitFire;
  logic            w_lastBit;
  logic            w_gapDone;
  logic [15:0]     w_curWord;
  logic [3:0]      w_bitIdx;
  logic            w_bit;

  // Field packing; the J format shares bit 6 between addr_offset[2] and jump_type.
  always_comb begin
    w_word0  = 16'h0000;
    w_double = 1'b0;
    w_reject = 1'b0;
    case (opcode)
      OP_R:   w_word0 = {alu_op, rd, rs2, rs1, opcode};
      OP_I: begin
        w_word0  = {alu_op, rd, 3'b000, rs1, opcode};
        w_double = 1'b1;
      end
      OP_B:   w_word0 = {b_type, offset, rs2, rs1, opcode};
      OP_J: begin
        w_word0  = {addr_offset[8:5], rd, addr_offset[4:0], 1'b0, opcode};
        w_reject = (jump_type != addr_offset[2]);
      end
      OP_M: begin
        w_word0  = {mem_op, rd, rs2, rs1, opcode};
        w_double = 1'b1;
      end
      OP_SYS: w_word0 = {13'h0000, opcode};
      default: w_reject = 1'b1;
    endcase
  end

  assign w_accept  = in_valid & in_ready & ~w_reject;
  assign w_sending = (r_state == SEND_W0) || (r_state == SEND_W1);
  assign w_bitFire = w_sending & ser_ready;
  assign w_lastBit = w_bitFire && (r_bitCnt == CW'(LAST_BIT));
  assign w_gapDone = (r_state == GAP) && (r_gapCnt == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_nextState = SEND_W0;
      end
      SEND_W0: begin
        if (w_lastBit) begin
          if (r_double)            w_nextState = SEND_W1;
          else if (GAP_CYCLES > 0) w_nextState = GAP;
          else                     w_nextState = IDLE;
        end
      end
      SEND_W1: begin
        if (w_lastBit) begin
          if (GAP_CYCLES > 0) w_nextState = GAP;
          else                w_nextState = IDLE;
        end
      end
      GAP: begin
        if (w_gapDone) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Word capture, bit counter and gap counter; the bit counter only moves on a handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word0  <= 16'h0000;
      r_word1  <= 16'h0000;
      r_double <= 1'b0;
      r_bitCnt <= '0;
      r_gapCnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= in_valid & in_ready & w_reject;
      if (w_accept) begin
        r_word0  <= w_word0;
        r_word1  <= w_double ? imm : 16'h0000;
        r_double <= w_double;
        r_bitCnt <= '0;
      end else if (w_bitFire) begin
        r_bitCnt <= w_lastBit ? '0 : r_bitCnt + CW'(1);
      end
      if (r_state == GAP) r_gapCnt <= r_gapCnt + GW'(1);
      else                r_gapCnt <= '0;
    end
  end

  assign w_curWord = (r_state == SEND_W1) ? r_word1 : r_word0;
  assign w_bitIdx  = (LSB_FIRST != 0) ? r_bitCnt[3:0] : (4'd15 - r_bitCnt[3:0]);

`ifdef INSTR_ENC_PARITY_EN
  assign w_bit = (r_bitCnt == CW'(LAST_BIT)) ? ^w_curWord : w_curWord[w_bitIdx];
`else
  assign w_bit = w_curWord[w_bitIdx];
`endif

  assign ser_valid = w_sending;
  assign ser_data  = w_sending & w_bit;
  assign ser_first = w_sending & (r_bitCnt == '0);
  assign err       = r_err;

endmodule
